// File: rtl/game_board_pkg.sv
// Shared types for the battle board: cell codes, game phases, shot result
// codes and a small range-check helper used by the board and its grids.
package game_board_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SHIP  = 2'b01,
    HIT   = 2'b10,
    MISS  = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_CLEAR = 3'd1,
    P_PLACE = 3'd2,
    P_PLAY  = 3'd3,
    P_OVER  = 3'd4
  } phase_t;

  localparam logic [1:0] RES_REJ  = 2'b00;
  localparam logic [1:0] RES_HIT  = 2'b10;
  localparam logic [1:0] RES_MISS = 2'b11;

  // True when (r,c) lies on an n x n board.
  function automatic logic in_grid(input int r, input int c, input int n);
    return (r < n) && (c < n);
  endfunction

endpackage

// File: rtl/battle_grid.sv
// One BOARD_SIZE x BOARD_SIZE board of 2-bit cells: single write port,
// whole-row clear for the sweep, combinational peek of the write address
// (used for the accept checks) and a registered display read port.
module battle_grid
  import game_board_pkg::*;
#(
  parameter int BOARD_SIZE = 10,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_en,
  input  logic [CW-1:0] clr_row,
  input  logic          we,
  input  logic [CW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [1:0]    wr_data,
  output logic [1:0]    peek,
  input  logic [CW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [1:0]    rd_code
);

  logic [BOARD_SIZE-1:0][BOARD_SIZE-1:0][1:0] mem;
  logic wr_in, rd_in;

  assign wr_in = in_grid(int'(wr_row), int'(wr_col), BOARD_SIZE);
  assign rd_in = in_grid(int'(rd_row), int'(rd_col), BOARD_SIZE);
  assign peek  = wr_in ? mem[wr_row][wr_col] : EMPTY;

  // Cell storage: row clear and cell write never overlap (different phases).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      if (clr_en) mem[clr_row] <= '0;
      if (we && wr_in) mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Display read, one cycle latency; off-board addresses read as EMPTY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_code <= EMPTY;
    else        rd_code <= rd_in ? mem[rd_row][rd_col] : EMPTY;
  end

endmodule

// File: rtl/battle_board.sv
// One player's own and enemy boards with the game-phase FSM, board clear
// sweep, placement and incoming-shot handshakes and win/loss counters.
// Optional macro BATTLE_BOARD_UNDO_EN: clicking a placed ship in PLACE
// removes it again.
module battle_board
  import game_board_pkg::*;
#(
  parameter  int BOARD_SIZE = 10,
  parameter  int SHIP_CELLS = 20,
  localparam int CW         = (BOARD_SIZE > 1) ? $clog2(BOARD_SIZE) : 1,
  localparam int NW         = $clog2(SHIP_CELLS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          place_valid,
  input  logic [CW-1:0] place_row,
  input  logic [CW-1:0] place_col,
  output logic          place_ack,
  output logic          place_ok,
  input  logic          in_shot_valid,
  output logic          in_shot_ready,
  input  logic [CW-1:0] in_shot_row,
  input  logic [CW-1:0] in_shot_col,
  output logic          in_res_valid,
  output logic [1:0]    in_res_code,
  input  logic          out_res_valid,
  input  logic [CW-1:0] out_res_row,
  input  logic [CW-1:0] out_res_col,
  input  logic [1:0]    out_res_code,
  input  logic [CW-1:0] rd_own_row,
  input  logic [CW-1:0] rd_own_col,
  input  logic [CW-1:0] rd_enemy_row,
  input  logic [CW-1:0] rd_enemy_col,
  output logic [1:0]    rd_own_code,
  output logic [1:0]    rd_enemy_code,
  output logic [2:0]    phase,
  output logic [NW-1:0] ships_placed,
  output logic [NW-1:0] own_hits,
  output logic [NW-1:0] enemy_hits,
  output logic          won,
  output logic          lost
);

  localparam logic [NW-1:0] NSHIP = NW'(SHIP_CELLS);
  localparam logic [CW-1:0] LAST  = CW'(BOARD_SIZE - 1);

  phase_t        phase_q, phase_d;
  logic [CW-1:0] clr_q, clr_d;
  logic [NW-1:0] ships_q, ships_d, own_q, own_d, en_q, en_d;
  logic          won_d, lost_d, ack_d, ok_d, rv_d;
  logic [1:0]    rc_d;

  logic          own_we, en_we;
  logic [1:0]    own_wdata, own_peek, en_peek;
  logic [CW-1:0] own_row, own_col;
  logic          shot_hs, place_in, shot_in, res_in;

  // Own board is written by placement in PLACE and by shots in PLAY only.
  assign own_row  = (phase_q == P_PLACE) ? place_row : in_shot_row;
  assign own_col  = (phase_q == P_PLACE) ? place_col : in_shot_col;
  assign place_in = in_grid(int'(place_row), int'(place_col), BOARD_SIZE);
  assign shot_in  = in_grid(int'(in_shot_row), int'(in_shot_col), BOARD_SIZE);
  assign res_in   = in_grid(int'(out_res_row), int'(out_res_col), BOARD_SIZE);

  // A start pulse abandons the game, so no shot is taken on that cycle.
  assign in_shot_ready = (phase_q == P_PLAY) && !start;
  assign shot_hs       = in_shot_valid && in_shot_ready;

  assign phase        = phase_q;
  assign ships_placed = ships_q;
  assign own_hits     = own_q;
  assign enemy_hits   = en_q;

  battle_grid #(.BOARD_SIZE(BOARD_SIZE), .CW(CW)) u_own (
    .clk(clk), .rst_n(rst_n), .clr_en(phase_q == P_CLEAR), .clr_row(clr_q),
    .we(own_we), .wr_row(own_row), .wr_col(own_col), .wr_data(own_wdata),
    .peek(own_peek), .rd_row(rd_own_row), .rd_col(rd_own_col), .rd_code(rd_own_code)
  );

  battle_grid #(.BOARD_SIZE(BOARD_SIZE), .CW(CW)) u_enemy (
    .clk(clk), .rst_n(rst_n), .clr_en(phase_q == P_CLEAR), .clr_row(clr_q),
    .we(en_we), .wr_row(out_res_row), .wr_col(out_res_col), .wr_data(out_res_code),
    .peek(en_peek), .rd_row(rd_enemy_row), .rd_col(rd_enemy_col), .rd_code(rd_enemy_code)
  );

  // Next-state, board writes and handshake responses.
  always_comb begin
    phase_d   = phase_q;
    clr_d     = clr_q;
    ships_d   = ships_q;
    own_d     = own_q;
    en_d      = en_q;
    won_d     = won;
    lost_d    = lost;
    own_we    = 1'b0;
    own_wdata = EMPTY;
    en_we     = 1'b0;
    ack_d     = place_valid;
    ok_d      = 1'b0;
    rv_d      = 1'b0;
    rc_d      = RES_REJ;
    if (start) begin
      phase_d = P_CLEAR;
      clr_d   = '0;
      ships_d = '0;
      own_d   = '0;
      en_d    = '0;
      won_d   = 1'b0;
      lost_d  = 1'b0;
    end else begin
      unique case (phase_q)
        P_CLEAR: begin
          if (clr_q == LAST) phase_d = P_PLACE;
          else               clr_d   = clr_q + 1'b1;
        end
        P_PLACE: begin
          if (place_valid && place_in) begin
            if (own_peek == EMPTY && ships_q < NSHIP) begin
              own_we    = 1'b1;
              own_wdata = SHIP;
              ok_d      = 1'b1;
              ships_d   = ships_q + 1'b1;
              if (ships_d == NSHIP) phase_d = P_PLAY;
            end
`ifdef BATTLE_BOARD_UNDO_EN
            else if (own_peek == SHIP) begin
              own_we    = 1'b1;
              own_wdata = EMPTY;
              ok_d      = 1'b1;
              ships_d   = ships_q - 1'b1;
            end
`endif
          end
        end
        P_PLAY: begin
          if (shot_hs) begin
            rv_d = 1'b1;
            if (shot_in && own_peek == SHIP) begin
              own_we    = 1'b1;
              own_wdata = HIT;
              rc_d      = RES_HIT;
              if (own_q < NSHIP) own_d = own_q + 1'b1;
            end else if (shot_in && own_peek == EMPTY) begin
              own_we    = 1'b1;
              own_wdata = MISS;
              rc_d      = RES_MISS;
            end
          end
          if (out_res_valid && res_in && en_peek == EMPTY) begin
            en_we = 1'b1;
            if (out_res_code == HIT && en_q < NSHIP) en_d = en_q + 1'b1;
          end
          if (own_d == NSHIP) lost_d = 1'b1;
          if (en_d == NSHIP)  won_d  = 1'b1;
          if (lost_d || won_d) phase_d = P_OVER;
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= P_IDLE;
      clr_q        <= '0;
      ships_q      <= '0;
      own_q        <= '0;
      en_q         <= '0;
      won          <= 1'b0;
      lost         <= 1'b0;
      place_ack    <= 1'b0;
      place_ok     <= 1'b0;
      in_res_valid <= 1'b0;
      in_res_code  <= RES_REJ;
    end else begin
      phase_q      <= phase_d;
      clr_q        <= clr_d;
      ships_q      <= ships_d;
      own_q        <= own_d;
      en_q         <= en_d;
      won          <= won_d;
      lost         <= lost_d;
      place_ack    <= ack_d;
      place_ok     <= ok_d;
      in_res_valid <= rv_d;
      in_res_code  <= rc_d;
    end
  end

endmodule

// File: tb/tb_battle_board.sv
// Directed bench for battle_board: reset, clear sweep, placement, shots,
// recorded results, win, restart, undo/reject and reset during PLAY.
module tb_battle_board;
  import game_board_pkg::*;

  localparam int CW = 4;
  localparam int NW = 5;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic          place_valid = 1'b0, place_ack, place_ok;
  logic [CW-1:0] place_row = '0, place_col = '0;
  logic          in_shot_valid = 1'b0, in_shot_ready, in_res_valid;
  logic [CW-1:0] in_shot_row = '0, in_shot_col = '0;
  logic [1:0]    in_res_code;
  logic          out_res_valid = 1'b0;
  logic [CW-1:0] out_res_row = '0, out_res_col = '0;
  logic [1:0]    out_res_code = '0;
  logic [CW-1:0] rd_own_row = '0, rd_own_col = '0, rd_enemy_row = '0, rd_enemy_col = '0;
  logic [1:0]    rd_own_code, rd_enemy_code;
  logic [2:0]    phase;
  logic [NW-1:0] ships_placed, own_hits, enemy_hits;
  logic          won, lost;

  int total = 0;
  int bad   = 0;

  battle_board dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .place_valid(place_valid), .place_row(place_row), .place_col(place_col),
    .place_ack(place_ack), .place_ok(place_ok),
    .in_shot_valid(in_shot_valid), .in_shot_ready(in_shot_ready),
    .in_shot_row(in_shot_row), .in_shot_col(in_shot_col),
    .in_res_valid(in_res_valid), .in_res_code(in_res_code),
    .out_res_valid(out_res_valid), .out_res_row(out_res_row),
    .out_res_col(out_res_col), .out_res_code(out_res_code),
    .rd_own_row(rd_own_row), .rd_own_col(rd_own_col),
    .rd_enemy_row(rd_enemy_row), .rd_enemy_col(rd_enemy_col),
    .rd_own_code(rd_own_code), .rd_enemy_code(rd_enemy_code),
    .phase(phase), .ships_placed(ships_placed), .own_hits(own_hits),
    .enemy_hits(enemy_hits), .won(won), .lost(lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         r;
    int         c;
    logic [1:0] code;
    int         own;
  } shot_vec_t;

  shot_vec_t shots[4];
  int        pr[20];
  int        pc[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic place(input int r, input int c, output logic ok);
    place_row   = CW'(r);
    place_col   = CW'(c);
    place_valid = 1'b1;
    step();
    place_valid = 1'b0;
    chk("place_ack", 32'(place_ack), 1);
    ok = place_ok;
  endtask

  task automatic shoot(input int r, input int c);
    in_shot_row   = CW'(r);
    in_shot_col   = CW'(c);
    in_shot_valid = 1'b1;
    step();
    in_shot_valid = 1'b0;
    chk("in_res_valid", 32'(in_res_valid), 1);
  endtask

  task automatic result(input int r, input int c, input logic [1:0] code);
    out_res_row   = CW'(r);
    out_res_col   = CW'(c);
    out_res_code  = code;
    out_res_valid = 1'b1;
    step();
    out_res_valid = 1'b0;
  endtask

  task automatic rd_own(input int r, input int c, output logic [1:0] v);
    rd_own_row = CW'(r);
    rd_own_col = CW'(c);
    step();
    v = rd_own_code;
  endtask

  task automatic rd_enemy(input int r, input int c, output logic [1:0] v);
    rd_enemy_row = CW'(r);
    rd_enemy_col = CW'(c);
    step();
    v = rd_enemy_code;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts cycles spent in CLEAR; expects PLACE afterwards.
  task automatic run_clear(output int n);
    n = 0;
    while (phase == 3'(P_CLEAR) && n < 50) begin
      n++;
      step();
    end
    chk("clear_exit_phase", 32'(phase), 32'(P_PLACE));
  endtask

  initial begin
    logic       ok;
    logic [1:0] v;
    int         n, first;

    shots[0] = '{3, 4, 2'b10, 1};
    shots[1] = '{0, 0, 2'b11, 1};
    shots[2] = '{3, 4, 2'b00, 1};
    shots[3] = '{12, 0, 2'b00, 1};
    pr[0] = 3; pc[0] = 4;
    for (int i = 1; i < 20; i++) begin
      pr[i] = (i < 10) ? 0 : 1;
      pc[i] = (i < 10) ? i : i - 10;
    end

    // Reset state.
    repeat (2) step();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_ships", 32'(ships_placed), 0);
    chk("rst_won_lost", 32'({won, lost}), 0);
    chk("rst_ack", 32'(place_ack), 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", 32'(in_shot_ready), 0);

    // Placement outside PLACE is refused.
    place(2, 2, ok);
    chk("idle_place_ok", 32'(ok), 0);

    // Game 1: clear sweep length.
    pulse_start();
    chk("start_phase", 32'(phase), 32'(P_CLEAR));
    run_clear(n);
    chk("clear_cycles", 32'(n), 10);

    place(3, 4, ok);
    chk("place_first_ok", 32'(ok), 1);
    step();
    chk("ack_pulse_drops", 32'(place_ack), 0);
    place(3, 4, ok);
    chk("place_dup_ok", 32'(ok), 0);
    place(12, 0, ok);
    chk("place_oor_ok", 32'(ok), 0);
    chk("ships_one", 32'(ships_placed), 1);

    for (int i = 1; i < 19; i++) place(pr[i], pc[i], ok);
    chk("ships_19", 32'(ships_placed), 19);
    chk("phase_still_place", 32'(phase), 32'(P_PLACE));
    place(pr[19], pc[19], ok);
    chk("place_20_ok", 32'(ok), 1);
    chk("ships_20", 32'(ships_placed), 20);
    chk("phase_play", 32'(phase), 32'(P_PLAY));
    place(5, 5, ok);
    chk("place_21_ok", 32'(ok), 0);
    chk("ships_sat", 32'(ships_placed), 20);

    // Incoming shot table.
    chk("play_ready", 32'(in_shot_ready), 1);
    for (int i = 0; i < 4; i++) begin
      shoot(shots[i].r, shots[i].c);
      chk($sformatf("shot%0d_code", i), 32'(in_res_code), 32'(shots[i].code));
      chk($sformatf("shot%0d_own", i), 32'(own_hits), 32'(shots[i].own));
    end
    rd_own(3, 4, v);
    chk("rd_own_hit", 32'(v), 32'(HIT));
    rd_own(0, 0, v);
    chk("rd_own_miss", 32'(v), 32'(MISS));
    rd_own(12, 0, v);
    chk("rd_own_oor", 32'(v), 0);

    // Shot and result processed in the same cycle.
    in_shot_row = 4'd0; in_shot_col = 4'd1; in_shot_valid = 1'b1;
    out_res_row = 4'd0; out_res_col = 4'd0; out_res_code = 2'b10; out_res_valid = 1'b1;
    step();
    in_shot_valid = 1'b0; out_res_valid = 1'b0;
    chk("dual_code", 32'(in_res_code), 32'(RES_HIT));
    chk("dual_own", 32'(own_hits), 2);
    chk("dual_enemy", 32'(enemy_hits), 1);

    // Ignored results: repeat cell and off-board.
    result(0, 0, 2'b10);
    result(12, 3, 2'b10);
    chk("res_ignored", 32'(enemy_hits), 1);
    result(5, 5, 2'b11);
    chk("res_miss_nocount", 32'(enemy_hits), 1);
    rd_enemy(5, 5, v);
    chk("rd_enemy_miss", 32'(v), 32'(MISS));

    for (int i = 1; i < 19; i++) result(i / 10, i % 10, 2'b10);
    chk("enemy_19", 32'(enemy_hits), 19);
    chk("won_not_yet", 32'(won), 0);
    result(1, 9, 2'b10);
    chk("enemy_20", 32'(enemy_hits), 20);
    chk("won", 32'(won), 1);
    chk("lost", 32'(lost), 0);
    chk("phase_over", 32'(phase), 32'(P_OVER));
    chk("over_ready", 32'(in_shot_ready), 0);
    result(7, 7, 2'b10);
    rd_enemy(7, 7, v);
    chk("over_frozen", 32'(v), 32'(EMPTY));
    rd_enemy(0, 0, v);
    chk("over_rd_live", 32'(v), 32'(HIT));

    // Game 2: restart clears flags and boards.
    pulse_start();
    chk("restart_phase", 32'(phase), 32'(P_CLEAR));
    chk("restart_won", 32'(won), 0);
    chk("restart_enemy", 32'(enemy_hits), 0);
    run_clear(n);
    chk("clear2_cycles", 32'(n), 10);
    rd_own(0, 0, v);
    chk("cleared_own", 32'(v), 32'(EMPTY));
    rd_enemy(0, 0, v);
    chk("cleared_enemy", 32'(v), 32'(EMPTY));

    place(3, 4, ok);
    place(3, 4, ok);
`ifdef BATTLE_BOARD_UNDO_EN
    chk("undo_ok", 32'(ok), 1);
    chk("undo_ships", 32'(ships_placed), 0);
    rd_own(3, 4, v);
    chk("undo_cell", 32'(v), 32'(EMPTY));
    first = 0;
`else
    chk("reclick_ok", 32'(ok), 0);
    chk("reclick_ships", 32'(ships_placed), 1);
    rd_own(3, 4, v);
    chk("reclick_cell", 32'(v), 32'(SHIP));
    first = 1;
`endif
    for (int i = first; i < 20; i++) place(pr[i], pc[i], ok);
    chk("game2_play", 32'(phase), 32'(P_PLAY));
    shoot(1, 5);
    chk("game2_hit", 32'(own_hits), 1);

    // Asynchronous reset in the middle of PLAY.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_phase", 32'(phase), 0);
    chk("async_rst_cnt", 32'({ships_placed, own_hits, enemy_hits}), 0);
    step();
    rst_n = 1'b1;
    n = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        rd_own(r, c, v);
        if (v !== 2'b00) n++;
      end
    chk("rst_own_cells_nonempty", 32'(n), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
